// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin sharing of one ula_k ALU between two requesters.
// Operands are registered onto the ALU, held for ALU_LATENCY cycles, and the
// sampled result/overflow is returned on the owner's response handshake.
module ula_arbiter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [7:0]       req0_code,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [7:0]       req1_code,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_overflow,
  output logic             rsp0_error,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_overflow,
  output logic             rsp1_error,
  output logic [WIDTH-1:0] alu_operator1,
  output logic [WIDTH-1:0] alu_operator2,
  output logic [7:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow
);

  localparam int unsigned CNT_W    = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);
  localparam logic [7:0]  CODE_MAX = 8'd5;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e                      state_q, state_d;
  logic                        last_grant_q, last_grant_d;
  logic                        owner_q, owner_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [WIDTH-1:0]            op1_q, op1_d, op2_q, op2_d;
  logic [7:0]                  code_q, code_d;
  logic [1:0]                  rsp_valid_q, rsp_valid_d;
  logic [1:0][WIDTH-1:0]       rsp_result_q, rsp_result_d;
  logic [1:0]                  rsp_ovf_q, rsp_ovf_d;
  logic [1:0]                  rsp_err_q, rsp_err_d;

  logic                        grant_c;
  logic                        accept_c;
  logic [WIDTH-1:0]            sel_op1_c, sel_op2_c;
  logic [7:0]                  sel_code_c;
  logic                        sel_rsp_ready_c;

  // Round-robin grant: a tie goes to the requester not served last
  always_comb begin
    grant_c = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_c = ~last_grant_q;
    end else if (req1_valid) begin
      grant_c = 1'b1;
    end
    accept_c        = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
    sel_op1_c       = grant_c ? req1_op1  : req0_op1;
    sel_op2_c       = grant_c ? req1_op2  : req0_op2;
    sel_code_c      = grant_c ? req1_code : req0_code;
    sel_rsp_ready_c = owner_q ? rsp1_ready : rsp0_ready;
  end

  assign req0_ready = accept_c && !grant_c;
  assign req1_ready = accept_c && grant_c;

  // Next-state and next-output computation for the controller
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    code_d       = code_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          last_grant_d = grant_c;
          owner_d      = grant_c;
          if (sel_code_c <= CODE_MAX) begin
            op1_d   = sel_op1_c;
            op2_d   = sel_op2_c;
            code_d  = sel_code_c;
            cnt_d   = CNT_W'(ALU_LATENCY);
            state_d = EXEC;
          end else begin
            // Invalid code bypasses the ALU and answers with an error
            rsp_result_d[grant_c] = '0;
            rsp_ovf_d[grant_c]    = 1'b0;
            rsp_err_d[grant_c]    = 1'b1;
            rsp_valid_d[grant_c]  = 1'b1;
            state_d               = RESP;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_result_d[owner_q] = alu_result;
          rsp_ovf_d[owner_q]    = alu_overflow;
          rsp_err_d[owner_q]    = 1'b0;
          rsp_valid_d[owner_q]  = 1'b1;
          state_d               = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q[owner_q] && sel_rsp_ready_c) begin
          rsp_valid_d[owner_q] = 1'b0;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      code_q       <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= '0;
      rsp_err_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      code_q       <= code_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_operator1 = op1_q;
  assign alu_operator2 = op2_q;
  assign alu_operation = code_q;
  assign rsp0_valid    = rsp_valid_q[0];
  assign rsp1_valid    = rsp_valid_q[1];
  assign rsp0_result   = rsp_result_q[0];
  assign rsp1_result   = rsp_result_q[1];
  assign rsp0_overflow = rsp_ovf_q[0];
  assign rsp1_overflow = rsp_ovf_q[1];
  assign rsp0_error    = rsp_err_q[0];
  assign rsp1_error    = rsp_err_q[1];

endmodule
